ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Sequences the single shared RAM port between instruction fetch (IF) and the MEM stage. It accepts the MEM stage's combinational RAM control outputs and the IF fetch request, and serializes them onto one variable-latency bus with a req/ready handshake. Data accesses always go before the fetch. It raises a pipeline stall until every request presented in the current cycle has completed, then returns the latched read data.

## Interface
Parameters: none. Widths come from the shared bus header: ADDR_BUS = 32, DATA_BUS = 32, MEM_SEL_BUS = 4.

Ports:
- `clk`  in  1  sole clock; every register updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `inst_en`  in  1  fetch request; held stable by the pipeline while `stall_req` = 1
- `inst_addr`  in  32  fetch address, word aligned
- `inst_rdata`  out  32  fetched word; registered
- `data_en`  in  1  MEM-stage RAM enable (read or write)
- `data_write_en`  in  4  byte write strobes; 0 means read
- `data_addr`  in  32  word-aligned data address
- `data_wdata`  in  32  lane-aligned write data
- `data_rdata`  out  32  data read word; registered
- `flush`  in  1  exception flush from the MEM stage
- `stall_req`  out  1  stall the whole pipeline; combinational
- `bus_req`  out  1  RAM transaction active
- `bus_write_en`  out  4  byte strobes for the current transaction
- `bus_addr`  out  32  address for the current transaction
- `bus_wdata`  out  32  write data for the current transaction
- `bus_rdata`  in  32  RAM read data; valid when `bus_ready` = 1
- `bus_ready`  in  1  completes the current transaction (one beat)

## Operation
The FSM has four states: IDLE, DATA, INST, RELEASE.

IDLE:
- `flush` = 1: no transaction starts and `stall_req` = 0.
- `data_en` = 1: capture `data_*` into the request registers; next state DATA.
- `inst_en` = 1 (no `data_en`): capture `inst_addr` with strobes 0; next state INST.
- Neither request: stay in IDLE.

DATA:
- `bus_req` = 1.
- On `bus_ready`, load `data_rdata` from `bus_rdata`. This happens for writes too; the value is then don't-care.
- If `inst_en` = 1 and `flush` = 0, capture `inst_addr` and go to INST. Otherwise go to RELEASE.

INST:
- `bus_req` = 1.
- On `bus_ready`, load `inst_rdata` from `bus_rdata` and go to RELEASE.

RELEASE:
- `stall_req` = 0 and `bus_req` = 0, so the pipeline advances this cycle.
- Requests still asserted this cycle are ignored; they belong to the instruction that is leaving.
- Next state IDLE.

Stall and bus outputs:
- `stall_req` = (IDLE & (`data_en` | `inst_en`) & !`flush`) | DATA | INST.
- `bus_write_en`, `bus_addr` and `bus_wdata` come straight from the request registers. They are stable for the whole transaction and are 0 in IDLE and RELEASE.
- A beat already on the bus is never abandoned.

Flush while a beat is outstanding:
- `flush` = 1 in DATA or INST sets a `flush_seen` flag.
- The beat runs to completion.
- The captured data is still written, but the next state is IDLE rather than INST or RELEASE.
- `stall_req` stays 1 until `bus_ready`.
- `flush_seen` clears in IDLE.

Addresses and strobes pass through untouched; this block performs no alignment or extension.

## Timing
- Reset values: state IDLE; `bus_req` 0; `bus_write_en` 0; `bus_addr` 0; `bus_wdata` 0; `inst_rdata` 0; `data_rdata` 0; `flush_seen` 0. `stall_req` is forced to 0 while `rst` = 1.
- Single access with zero-wait RAM (`bus_ready` in the first cycle of DATA or INST):
  - cycle 0: IDLE, stall asserted
  - cycle 1: bus beat
  - cycle 2: RELEASE, stall low, rdata valid
- Each added wait cycle adds one stall cycle.
- Data plus fetch in the same cycle: the stall covers IDLE, both beats and the wait cycles; `inst_rdata` and `data_rdata` are both valid in RELEASE.
- Read data stays valid from RELEASE until the next capture.
- `rst` during DATA or INST returns to IDLE on the next edge and drops `bus_req`. The RAM side must tolerate a dropped request.

## Structure
- Shared header `bus.v` (existing): ADDR_BUS, DATA_BUS, MEM_SEL_BUS.
- New shared header `arbiter.v`: state encodings ARB_IDLE = 2'd0, ARB_DATA = 2'd1, ARB_INST = 2'd2, ARB_RELEASE = 2'd3.
- One sub-module, `ram_req_latch`: a loadable register for strobes, address and wdata, with a synchronous clear. The arbiter instantiates it once and muxes its load source between data and inst.

## Test plan
- Reset behaviour: `rst` = 1 with `data_en` = 1 → `stall_req` = 0 and all bus outputs 0. The cycle after release, state is IDLE.
- Zero-wait read: `data_en` = 1, `data_addr` = 0x0000_1004, `bus_rdata` = 0xDEADBEEF with `bus_ready` in cycle 1 → `bus_addr` = 0x1004 in cycle 1, stall in cycles 0–1, `data_rdata` = 0xDEADBEEF in cycle 2.
- Simultaneous requests with two-wait RAM: data write (`data_write_en` = 4'b0011, `data_wdata` = 0x0000_ABCD, `data_addr` = 0x2000) plus fetch at 0xBFC0_0000 → the data beat is issued first with strobes 0011, then the fetch. Stall lasts 7 cycles; `inst_rdata` is captured.
- Stability: `bus_ready` held 0 for 5 cycles while the request inputs are toggled → `bus_addr`, `bus_write_en` and `bus_wdata` do not change.
- Flush mid-beat: `flush` in cycle 1 of DATA with `inst_en` = 1 → the data beat completes, no INST beat is issued, and the FSM goes to IDLE with no RELEASE cycle.
- Back-to-back: a second request held through RELEASE → it is ignored in RELEASE and a new transaction starts from IDLE the following cycle.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared widths, FSM encoding and request record for the RAM port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_port_arbiter_pkg;

   localparam int ADDR_BUS    = 32;
   localparam int DATA_BUS    = 32;
   localparam int MEM_SEL_BUS = 4;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_DATA    = 2'd1,
      ARB_INST    = 2'd2,
      ARB_RELEASE = 2'd3
   } arb_state_e;

   // One bus transaction as seen by the RAM: strobes, address, write data.
   typedef struct packed {
      logic [MEM_SEL_BUS-1:0] write_en;
      logic [ADDR_BUS-1:0]    addr;
      logic [DATA_BUS-1:0]    wdata;
   } ram_req_t;

endpackage

// File: rtl/ram_port_arbiter_req_latch.sv
// Loadable request register driving the shared RAM bus fields.
// Latency: load/clear take effect on the next rising edge.
// Backpressure: none; the owner decides when to load, hold or clear.
module ram_req_latch
   import ram_port_arbiter_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     clr_i,
   input  logic     load_i,
   input  ram_req_t req_i,
   output ram_req_t req_o
);

   ram_req_t req_q;

   // Clear wins over load so the bus reads zero whenever no beat is running.
   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         req_q <= '0;
      end else if (load_i) begin
         req_q <= req_i;
      end
   end

   assign req_o = req_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// Serializes MEM-stage data access then IF fetch onto one req/ready RAM port.
// Latency: one IDLE cycle, one bus cycle per beat plus RAM waits, one RELEASE cycle.
// Backpressure: stall_req holds the pipeline until all beats of this cycle complete.
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   inst_en,
   input  logic [ADDR_BUS-1:0]    inst_addr,
   output logic [DATA_BUS-1:0]    inst_rdata,
   input  logic                   data_en,
   input  logic [MEM_SEL_BUS-1:0] data_write_en,
   input  logic [ADDR_BUS-1:0]    data_addr,
   input  logic [DATA_BUS-1:0]    data_wdata,
   output logic [DATA_BUS-1:0]    data_rdata,
   input  logic                   flush,
   output logic                   stall_req,
   output logic                   bus_req,
   output logic [MEM_SEL_BUS-1:0] bus_write_en,
   output logic [ADDR_BUS-1:0]    bus_addr,
   output logic [DATA_BUS-1:0]    bus_wdata,
   input  logic [DATA_BUS-1:0]    bus_rdata,
   input  logic                   bus_ready
);

   arb_state_e          state_q, state_d;
   logic                flush_seen_q, flush_seen_d;
   logic [DATA_BUS-1:0] inst_rdata_q, inst_rdata_d;
   logic [DATA_BUS-1:0] data_rdata_q, data_rdata_d;

   logic     req_load;
   logic     req_clr;
   ram_req_t req_src;
   ram_req_t req_cur;
   ram_req_t data_req;
   ram_req_t inst_req;
   logic     flush_any;

   assign data_req  = '{write_en: data_write_en, addr: data_addr, wdata: data_wdata};
   assign inst_req  = '{write_en: '0, addr: inst_addr, wdata: '0};
   // A flush seen at any point of the current beat cancels whatever would follow it.
   assign flush_any = flush | flush_seen_q;

   ram_req_latch u_req_latch (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (req_clr),
      .load_i (req_load),
      .req_i  (req_src),
      .req_o  (req_cur)
   );

   // State, flush flag and returned read data registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         flush_seen_q <= 1'b0;
         inst_rdata_q <= '0;
         data_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         flush_seen_q <= flush_seen_d;
         inst_rdata_q <= inst_rdata_d;
         data_rdata_q <= data_rdata_d;
      end
   end

   // Next state, request latch control, read-data capture and stall decode.
   always_comb begin
      state_d      = state_q;
      flush_seen_d = flush_seen_q;
      inst_rdata_d = inst_rdata_q;
      data_rdata_d = data_rdata_q;
      req_load     = 1'b0;
      req_clr      = 1'b0;
      req_src      = data_req;
      stall_req    = 1'b0;

      case (state_q)
         ARB_IDLE: begin
            flush_seen_d = 1'b0;
            req_clr      = 1'b1;
            if (!flush && (data_en || inst_en)) begin
               stall_req = 1'b1;
               req_clr   = 1'b0;
               req_load  = 1'b1;
               if (data_en) begin
                  req_src = data_req;
                  state_d = ARB_DATA;
               end else begin
                  req_src = inst_req;
                  state_d = ARB_INST;
               end
            end
         end
         ARB_DATA: begin
            stall_req = 1'b1;
            if (flush) begin
               flush_seen_d = 1'b1;
            end
            if (bus_ready) begin
               // Loaded for writes too; the value is meaningless then.
               data_rdata_d = bus_rdata;
               if (flush_any) begin
                  req_clr = 1'b1;
                  state_d = ARB_IDLE;
               end else if (inst_en) begin
                  req_src  = inst_req;
                  req_load = 1'b1;
                  state_d  = ARB_INST;
               end else begin
                  req_clr = 1'b1;
                  state_d = ARB_RELEASE;
               end
            end
         end
         ARB_INST: begin
            stall_req = 1'b1;
            if (flush) begin
               flush_seen_d = 1'b1;
            end
            if (bus_ready) begin
               inst_rdata_d = bus_rdata;
               req_clr      = 1'b1;
               state_d      = flush_any ? ARB_IDLE : ARB_RELEASE;
            end
         end
         ARB_RELEASE: begin
            // Requests seen here belong to the departing instruction.
            req_clr = 1'b1;
            state_d = ARB_IDLE;
         end
         default: begin
            req_clr = 1'b1;
            state_d = ARB_IDLE;
         end
      endcase

      if (rst) begin
         stall_req = 1'b0;
      end
   end

   assign bus_req      = (state_q == ARB_DATA) || (state_q == ARB_INST);
   assign bus_write_en = req_cur.write_en;
   assign bus_addr     = req_cur.addr;
   assign bus_wdata    = req_cur.wdata;
   assign inst_rdata   = inst_rdata_q;
   assign data_rdata   = data_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: queue-based model plus directed scenarios.
// Latency: n/a.
// Backpressure: a RAM responder with programmable wait states and a hold override.
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_en;
   logic [31:0] inst_addr;
   logic [31:0] inst_rdata;
   logic        data_en;
   logic [3:0]  data_write_en;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        flush;
   logic        stall_req;
   logic        bus_req;
   logic [3:0]  bus_write_en;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata = 32'h0;
   logic        bus_ready = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ram_port_arbiter dut (
      .clk           (clk),
      .rst           (rst),
      .inst_en       (inst_en),
      .inst_addr     (inst_addr),
      .inst_rdata    (inst_rdata),
      .data_en       (data_en),
      .data_write_en (data_write_en),
      .data_addr     (data_addr),
      .data_wdata    (data_wdata),
      .data_rdata    (data_rdata),
      .flush         (flush),
      .stall_req     (stall_req),
      .bus_req       (bus_req),
      .bus_write_en  (bus_write_en),
      .bus_addr      (bus_addr),
      .bus_wdata     (bus_wdata),
      .bus_rdata     (bus_rdata),
      .bus_ready     (bus_ready)
   );

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- RAM responder ----------------
   int ram_waits = 0;
   bit ram_hold  = 1'b0;
   int ram_cnt   = 0;

   always @(posedge clk) begin
      #2;
      if (bus_ready) ram_cnt = 0;
      if (bus_req) begin
         bus_ready = !ram_hold && (ram_cnt >= ram_waits);
         bus_rdata = (bus_addr == 32'h0000_1004) ? 32'hDEAD_BEEF : (bus_addr ^ 32'hA5A5_0F0F);
         ram_cnt++;
      end else begin
         bus_ready = 1'b0;
         bus_rdata = 32'h0;
         ram_cnt   = 0;
      end
   end

   // ---------------- behavioural model ----------------
   // Pending beats in issue order; a beat leaves the queue when the RAM accepts it.
   typedef struct {
      logic [3:0]  we;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          is_inst;
   } beat_t;

   beat_t       m_q[$];
   bit          m_release = 1'b0;
   bit          m_flush   = 1'b0;
   logic [31:0] m_inst_rd = 32'h0;
   logic [31:0] m_data_rd = 32'h0;
   bit          chk_en    = 1'b0;

   always @(posedge clk) begin
      beat_t h;
      if (rst) begin
         m_q.delete();
         m_release = 1'b0;
         m_flush   = 1'b0;
         m_inst_rd = 32'h0;
         m_data_rd = 32'h0;
      end else if (m_release) begin
         m_release = 1'b0;
      end else if (m_q.size() == 0) begin
         m_flush = 1'b0;
         if (!flush) begin
            if (data_en)
               m_q.push_back('{we: data_write_en, addr: data_addr, wdata: data_wdata, is_inst: 1'b0});
            else if (inst_en)
               m_q.push_back('{we: 4'h0, addr: inst_addr, wdata: 32'h0, is_inst: 1'b1});
         end
      end else begin
         h = m_q[0];
         if (flush) m_flush = 1'b1;
         if (bus_ready) begin
            void'(m_q.pop_front());
            if (h.is_inst) m_inst_rd = bus_rdata;
            else           m_data_rd = bus_rdata;
            if (m_flush)
               m_flush = 1'b0;
            else if (!h.is_inst && inst_en)
               m_q.push_back('{we: 4'h0, addr: inst_addr, wdata: 32'h0, is_inst: 1'b1});
            else
               m_release = 1'b1;
         end
      end
   end

   // One compare per cycle of every DUT output against the model.
   always @(negedge clk) begin
      logic [3:0]  e_we;
      logic [31:0] e_addr;
      logic [31:0] e_wd;
      logic        e_req;
      logic        e_stall;
      if (chk_en) begin
         e_req  = (m_q.size() > 0);
         e_we   = 4'h0;
         e_addr = 32'h0;
         e_wd   = 32'h0;
         if (e_req) begin
            e_we   = m_q[0].we;
            e_addr = m_q[0].addr;
            e_wd   = m_q[0].wdata;
         end
         e_stall = !rst && (e_req || (!m_release && (data_en || inst_en) && !flush));
         check32("m_stall_req", 32'(stall_req), 32'(e_stall));
         check32("m_bus_req", 32'(bus_req), 32'(e_req));
         check32("m_bus_write_en", 32'(bus_write_en), 32'(e_we));
         check32("m_bus_addr", bus_addr, e_addr);
         check32("m_bus_wdata", bus_wdata, e_wd);
         check32("m_inst_rdata", inst_rdata, m_inst_rd);
         check32("m_data_rdata", data_rdata, m_data_rd);
      end
   end

   // ---------------- stimulus ----------------
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      data_en       = 1'b0;
      inst_en       = 1'b0;
      flush         = 1'b0;
      data_write_en = 4'h0;
      data_addr     = 32'h0;
      data_wdata    = 32'h0;
      inst_addr     = 32'h0;
   endtask

   // Wait for the stall to drop (RELEASE), then drop requests in the following IDLE cycle.
   task automatic run_out(input int max);
      int k;
      k = 0;
      forever begin
         @(negedge clk);
         if (!stall_req || k > max) break;
         k++;
         nxt();
      end
      check32("run_out_budget", 32'(k > max), 32'h0);
      nxt();
      idle_inputs();
   endtask

   initial begin
      int stall_cnt;
      int inst_beats;

      // Reset with a request pending: stall forced low, bus quiet.
      rst = 1'b1;
      idle_inputs();
      data_en   = 1'b1;
      data_addr = 32'h0000_1004;
      nxt();
      chk_en = 1'b1;
      @(negedge clk);
      check32("rst_stall", 32'(stall_req), 32'h0);
      check32("rst_bus_req", 32'(bus_req), 32'h0);
      check32("rst_bus_addr", bus_addr, 32'h0);
      check32("rst_bus_we", 32'(bus_write_en), 32'h0);
      check32("rst_bus_wdata", bus_wdata, 32'h0);
      check32("rst_data_rdata", data_rdata, 32'h0);
      check32("rst_inst_rdata", inst_rdata, 32'h0);

      // Zero-wait read at 0x1004; cycle 0 is the first cycle out of reset (IDLE).
      nxt();
      rst       = 1'b0;
      ram_waits = 0;
      @(negedge clk);
      check32("zw_c0_stall", 32'(stall_req), 32'h1);
      check32("zw_c0_bus_req", 32'(bus_req), 32'h0);
      nxt();
      @(negedge clk);
      check32("zw_c1_bus_addr", bus_addr, 32'h0000_1004);
      check32("zw_c1_stall", 32'(stall_req), 32'h1);
      nxt();
      @(negedge clk);
      check32("zw_c2_stall", 32'(stall_req), 32'h0);
      check32("zw_c2_bus_req", 32'(bus_req), 32'h0);
      check32("zw_c2_data_rdata", data_rdata, 32'hDEAD_BEEF);
      nxt();
      idle_inputs();
      nxt();
      @(negedge clk);
      check32("zw_rdata_hold", data_rdata, 32'hDEAD_BEEF);

      // Data write plus fetch, two-wait RAM: data beat first, 7 stall cycles.
      nxt();
      ram_waits     = 2;
      data_en       = 1'b1;
      data_write_en = 4'b0011;
      data_wdata    = 32'h0000_ABCD;
      data_addr     = 32'h0000_2000;
      inst_en       = 1'b1;
      inst_addr     = 32'hBFC0_0000;
      stall_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!stall_req) break;
         stall_cnt++;
         if (i == 1) begin
            check32("sim_first_we", 32'(bus_write_en), 32'h3);
            check32("sim_first_addr", bus_addr, 32'h0000_2000);
            check32("sim_first_wdata", bus_wdata, 32'h0000_ABCD);
         end
         if (i == 4) begin
            check32("sim_second_addr", bus_addr, 32'hBFC0_0000);
            check32("sim_second_we", 32'(bus_write_en), 32'h0);
         end
         nxt();
      end
      check32("sim_stall_cycles", 32'(stall_cnt), 32'd7);
      check32("sim_inst_rdata", inst_rdata, 32'h1A65_0F0F);
      check32("sim_data_rdata", data_rdata, 32'hA5A5_2F0F);
      nxt();
      idle_inputs();

      // Stability: RAM holds off for 5 cycles while request inputs toggle.
      nxt();
      ram_waits     = 0;
      ram_hold      = 1'b1;
      data_en       = 1'b1;
      data_addr     = 32'h0000_3000;
      data_write_en = 4'b1100;
      data_wdata    = 32'h1111_2222;
      nxt();
      for (int k = 0; k < 5; k++) begin
         data_addr     = 32'h0000_3000 + 32'(k + 1) * 32'd4;
         data_write_en = ~data_write_en;
         data_wdata    = ~data_wdata;
         inst_addr     = 32'h0000_0100 * 32'(k + 1);
         @(negedge clk);
         check32("stab_bus_req", 32'(bus_req), 32'h1);
         check32("stab_bus_addr", bus_addr, 32'h0000_3000);
         check32("stab_bus_we", 32'(bus_write_en), 32'hC);
         check32("stab_bus_wdata", bus_wdata, 32'h1111_2222);
         nxt();
      end
      ram_hold = 1'b0;
      run_out(10);
      check32("stab_data_rdata", data_rdata, 32'hA5A5_3F0F);

      // Flush in the first DATA cycle with a fetch pending: no fetch beat, no RELEASE.
      nxt();
      ram_waits     = 2;
      data_en       = 1'b1;
      data_addr     = 32'h0000_4000;
      inst_en       = 1'b1;
      inst_addr     = 32'h0000_5000;
      inst_beats    = 0;
      nxt();
      flush = 1'b1;
      @(negedge clk);
      check32("fl_c1_stall", 32'(stall_req), 32'h1);
      check32("fl_c1_bus_req", 32'(bus_req), 32'h1);
      nxt();
      flush = 1'b0;
      for (int c = 2; c <= 4; c++) begin
         @(negedge clk);
         if (bus_req && bus_addr == 32'h0000_5000) inst_beats++;
         if (c < 4) nxt();
      end
      check32("fl_c4_bus_req", 32'(bus_req), 32'h0);
      check32("fl_c4_stall_idle", 32'(stall_req), 32'h1);
      check32("fl_data_rdata", data_rdata, 32'hA5A5_4F0F);
      check32("fl_no_inst_beat", 32'(inst_beats), 32'h0);
      nxt();
      run_out(20);

      // Back-to-back: request held through RELEASE restarts from IDLE afterwards.
      nxt();
      ram_waits = 0;
      data_en   = 1'b1;
      data_addr = 32'h0000_6000;
      nxt();
      nxt();
      @(negedge clk);
      check32("b2b_rel_stall", 32'(stall_req), 32'h0);
      check32("b2b_rel_bus_req", 32'(bus_req), 32'h0);
      nxt();
      @(negedge clk);
      check32("b2b_idle_stall", 32'(stall_req), 32'h1);
      check32("b2b_idle_bus_req", 32'(bus_req), 32'h0);
      nxt();
      @(negedge clk);
      check32("b2b_beat_bus_req", 32'(bus_req), 32'h1);
      check32("b2b_beat_addr", bus_addr, 32'h0000_6000);
      run_out(10);

      // Reset during DATA: stall forced low at once, bus request dropped next edge.
      nxt();
      ram_waits = 3;
      data_en   = 1'b1;
      data_addr = 32'h0000_7000;
      nxt();
      rst = 1'b1;
      @(negedge clk);
      check32("rd_stall_forced", 32'(stall_req), 32'h0);
      check32("rd_bus_req_still", 32'(bus_req), 32'h1);
      nxt();
      rst = 1'b0;
      idle_inputs();
      @(negedge clk);
      check32("rd_bus_req_drop", 32'(bus_req), 32'h0);
      check32("rd_bus_addr_zero", bus_addr, 32'h0);
      check32("rd_data_rdata_zero", data_rdata, 32'h0);

      // Fetch only, zero-wait.
      nxt();
      ram_waits = 0;
      inst_en   = 1'b1;
      inst_addr = 32'h0000_8000;
      run_out(10);
      check32("if_inst_rdata", inst_rdata, 32'hA5A5_8F0F);

      nxt();
      nxt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
